// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with IF/ID register; ports: clk/clrn, decode redirect (bpc, jpc, ra, pcsource, wpcir), imem handshake (imem_req/addr/ack/rdata), IF/ID outputs (pc4, inst, inst_valid)
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] ra,
  input  logic [1:0]  pcsource,
  input  logic        wpcir,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc4,
  output logic [31:0] inst,
  output logic        inst_valid
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;
  state_t state;
  logic [31:0] addr_q, tgt_q, hold_q, sel, target, seq;
  logic redirect;
  assign sel = pcsource == 2'b01 ? bpc : pcsource == 2'b10 ? ra : jpc;
  assign target = sel & 32'hFFFF_FFFC;
  assign seq = addr_q + 32'd4;
  assign redirect = inst_valid & wpcir & (pcsource != 2'b00);
  assign imem_req = state == REQ || state == DRAIN;
  assign imem_addr = addr_q;
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      addr_q <= RESET_PC;
      tgt_q <= '0;
      hold_q <= '0;
      pc4 <= '0;
      inst <= '0;
      inst_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ:
          if (redirect) begin
            inst_valid <= 1'b0;
            if (imem_ack) addr_q <= target;
            else begin
              tgt_q <= target;
              state <= DRAIN;
            end
          end else if (imem_ack && wpcir) begin
            pc4 <= seq;
            inst <= imem_rdata;
            inst_valid <= 1'b1;
            addr_q <= seq;
          end else if (imem_ack) begin
            hold_q <= imem_rdata;
            state <= HOLD;
          end else if (wpcir) begin
            inst_valid <= 1'b0;
            inst <= '0;
          end
        HOLD:
          if (wpcir) begin
            state <= REQ;
            if (redirect) begin
              inst_valid <= 1'b0;
              addr_q <= target;
            end else begin
              pc4 <= seq;
              inst <= hold_q;
              inst_valid <= 1'b1;
              addr_q <= seq;
            end
          end
        DRAIN: begin
          if (imem_ack) begin
            addr_q <= tgt_q;
            state <= REQ;
          end
          if (wpcir) inst_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed vector table, reset/wrap sequences and randomized run against a behavioural fetch model
module tb_if_stage;
  logic clk = 1'b0;
  logic clrn = 1'b1;
  logic [31:0] bpc = '0, jpc = '0, ra = '0;
  logic [1:0] pcsource = '0;
  logic wpcir = 1'b1;
  logic imem_ack = 1'b0;
  logic imem_req;
  logic [31:0] imem_addr, imem_rdata, pc4, inst;
  logic inst_valid;
  logic scramble = 1'b0;
  int n_tests = 0;
  int n_fail = 0;

  if_stage dut (
    .clk(clk), .clrn(clrn), .bpc(bpc), .jpc(jpc), .ra(ra), .pcsource(pcsource),
    .wpcir(wpcir), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .pc4(pc4), .inst(inst), .inst_valid(inst_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return scramble ? {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'hC3A5} : a;
  endfunction
  assign imem_rdata = mem(imem_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic r, input logic [31:0] a,
                         input logic [31:0] p, input logic [31:0] i, input logic v);
    chk({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, r});
    chk({tag, ".imem_addr"}, imem_addr, a);
    chk({tag, ".pc4"}, pc4, p);
    chk({tag, ".inst"}, inst, i);
    chk({tag, ".inst_valid"}, {31'd0, inst_valid}, {31'd0, v});
  endtask

  typedef struct {
    logic ack, wp;
    logic [1:0] ps;
    logic [31:0] tgt;
    logic req;
    logic [31:0] addr, pc4, inst;
    logic v;
  } vec_t;

  task automatic step(input vec_t t, input string tag);
    imem_ack = t.ack; wpcir = t.wp; pcsource = t.ps;
    bpc = t.tgt; jpc = t.tgt; ra = t.tgt;
    @(posedge clk);
    @(negedge clk);
    chk_out(tag, t.req, t.addr, t.pc4, t.inst, t.v);
  endtask

  // behavioural fetch model
  logic m_started, m_held, m_drain, m_valid;
  logic [31:0] m_pc, m_tgt, m_hw, m_pc4, m_inst;

  task automatic m_reset();
    m_started = 0; m_held = 0; m_drain = 0; m_valid = 0;
    m_pc = 32'h0; m_tgt = 0; m_hw = 0; m_pc4 = 0; m_inst = 0;
  endtask

  task automatic m_deliver(input logic [31:0] w);
    m_pc4 = m_pc + 32'd4; m_inst = w; m_valid = 1; m_pc = m_pc + 32'd4;
  endtask

  task automatic m_step(input logic ack, input logic [31:0] rd);
    logic [31:0] t;
    logic redir;
    t = (pcsource == 2'd1 ? bpc : pcsource == 2'd2 ? ra : jpc) & 32'hFFFF_FFFC;
    redir = m_valid && wpcir && pcsource != 2'd0;
    if (!m_started) m_started = 1;
    else if (m_held) begin
      if (wpcir) begin
        m_held = 0;
        if (redir) begin m_valid = 0; m_pc = t; end
        else m_deliver(m_hw);
      end
    end else if (m_drain) begin
      if (ack) begin m_drain = 0; m_pc = m_tgt; end
      if (wpcir) m_valid = 0;
    end else if (redir) begin
      m_valid = 0;
      if (ack) m_pc = t;
      else begin m_drain = 1; m_tgt = t; end
    end else if (ack) begin
      if (wpcir) m_deliver(rd);
      else begin m_held = 1; m_hw = rd; end
    end else if (wpcir) begin
      m_valid = 0; m_inst = 0;
    end
  endtask

  vec_t tbl[27];
  vec_t h;

  initial begin
    tbl = '{
      '{1'b1,1'b1,2'd0,32'h0,   1'b1,32'h000,32'h000,32'h000,1'b0},
      '{1'b1,1'b1,2'd0,32'h0,   1'b1,32'h004,32'h004,32'h000,1'b1},
      '{1'b1,1'b1,2'd0,32'h0,   1'b1,32'h008,32'h008,32'h004,1'b1},
      '{1'b1,1'b1,2'd0,32'h0,   1'b1,32'h00C,32'h00C,32'h008,1'b1},
      '{1'b1,1'b1,2'd0,32'h0,   1'b1,32'h010,32'h010,32'h00C,1'b1},
      '{1'b0,1'b1,2'd0,32'h0,   1'b1,32'h010,32'h010,32'h000,1'b0},
      '{1'b0,1'b1,2'd0,32'h0,   1'b1,32'h010,32'h010,32'h000,1'b0},
      '{1'b0,1'b1,2'd0,32'h0,   1'b1,32'h010,32'h010,32'h000,1'b0},
      '{1'b1,1'b1,2'd0,32'h0,   1'b1,32'h014,32'h014,32'h010,1'b1},
      '{1'b1,1'b1,2'd0,32'h0,   1'b1,32'h018,32'h018,32'h014,1'b1},
      '{1'b1,1'b1,2'd0,32'h0,   1'b1,32'h01C,32'h01C,32'h018,1'b1},
      '{1'b1,1'b1,2'd0,32'h0,   1'b1,32'h020,32'h020,32'h01C,1'b1},
      '{1'b1,1'b0,2'd0,32'h0,   1'b0,32'h020,32'h020,32'h01C,1'b1},
      '{1'b0,1'b0,2'd0,32'h0,   1'b0,32'h020,32'h020,32'h01C,1'b1},
      '{1'b0,1'b1,2'd0,32'h0,   1'b1,32'h024,32'h024,32'h020,1'b1},
      '{1'b1,1'b1,2'd1,32'h100, 1'b1,32'h100,32'h024,32'h020,1'b0},
      '{1'b1,1'b1,2'd0,32'h0,   1'b1,32'h104,32'h104,32'h100,1'b1},
      '{1'b1,1'b1,2'd1,32'h038, 1'b1,32'h038,32'h104,32'h100,1'b0},
      '{1'b1,1'b1,2'd0,32'h0,   1'b1,32'h03C,32'h03C,32'h038,1'b1},
      '{1'b1,1'b1,2'd0,32'h0,   1'b1,32'h040,32'h040,32'h03C,1'b1},
      '{1'b0,1'b1,2'd3,32'h200, 1'b1,32'h040,32'h040,32'h03C,1'b0},
      '{1'b0,1'b1,2'd3,32'h200, 1'b1,32'h040,32'h040,32'h03C,1'b0},
      '{1'b1,1'b1,2'd0,32'h0,   1'b1,32'h200,32'h040,32'h03C,1'b0},
      '{1'b1,1'b1,2'd0,32'h0,   1'b1,32'h204,32'h204,32'h200,1'b1},
      '{1'b1,1'b1,2'd2,32'h303, 1'b1,32'h300,32'h204,32'h200,1'b0},
      '{1'b1,1'b1,2'd0,32'h0,   1'b1,32'h304,32'h304,32'h300,1'b1},
      '{1'b0,1'b1,2'd1,32'h500, 1'b1,32'h304,32'h304,32'h300,1'b0}
    };
    #2 clrn = 1'b0;
    #1 chk_out("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    clrn = 1'b1;
    for (int i = 0; i < 27; i++) step(tbl[i], $sformatf("vec%0d", i));
    // asynchronous reset while draining, then restart and wrap past the top of memory
    clrn = 1'b0;
    #1 chk_out("drain_rst", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    clrn = 1'b1;
    h = '{1'b1,1'b1,2'd0,32'h0,        1'b1,32'h0,32'h0,32'h0,1'b0};          step(h, "rst_first");
    h = '{1'b1,1'b1,2'd0,32'h0,        1'b1,32'h4,32'h4,32'h0,1'b1};          step(h, "rst_seq");
    h = '{1'b1,1'b1,2'd1,32'hFFFF_FFFF,1'b1,32'hFFFF_FFFC,32'h4,32'h0,1'b0};  step(h, "wrap_tgt");
    h = '{1'b1,1'b1,2'd0,32'h0,        1'b1,32'h0,32'h0,32'hFFFF_FFFC,1'b1};  step(h, "wrap_seq");
    // randomized run against the model
    scramble = 1'b1;
    clrn = 1'b0;
    m_reset();
    @(negedge clk);
    clrn = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        clrn = 1'b0;
        #1 m_reset();
        chk_out("rnd_rst", 1'b0, m_pc, m_pc4, m_inst, m_valid);
        @(negedge clk);
        clrn = 1'b1;
      end else begin
        imem_ack = $urandom_range(0, 3) != 0;
        wpcir = $urandom_range(0, 4) != 0;
        pcsource = $urandom_range(0, 2) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
        bpc = $urandom; jpc = $urandom; ra = $urandom;
        m_step(imem_ack, mem(m_pc));
        @(posedge clk);
        @(negedge clk);
        chk_out("rnd", m_started && !m_held, m_pc, m_pc4, m_inst, m_valid);
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: address of the first fetch after reset.
REQ-002 clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 clrn  in  1  reset, asynchronous, active-low.
REQ-004 bpc  in  32  branch target from decode.
REQ-005 jpc  in  32  jump target from decode.
REQ-006 ra  in  32  register-indirect target (decode operand a).
REQ-007 pcsource  in  2  decode's next-PC select: 00 sequential, 01 bpc, 10 ra, 11 jpc.
REQ-008 wpcir  in  1  hazard-unit enable; 0 = decode stalled, IF/ID must not change.
REQ-009 imem_req  out  1  instruction-memory request.
REQ-010 imem_addr  out  32  fetch address, word aligned.
REQ-011 imem_ack  in  1  memory accepts the request and returns imem_rdata in the same cycle.
REQ-012 imem_rdata  in  32  fetched instruction word.
REQ-013 pc4  out  32  fetched instruction address + 4, registered (IF/ID).
REQ-014 inst  out  32  fetched instruction, registered (IF/ID).
REQ-015 inst_valid  out  1  IF/ID holds a real instruction; 0 = bubble.

Function
REQ-016 State register SHALL have states IDLE, REQ, HOLD, DRAIN; internal registers addr_q (32), tgt_q (32), hold_q (32).
REQ-017 imem_req SHALL be 1 exactly in REQ and DRAIN; imem_addr SHALL equal addr_q at all times.
REQ-018 Once imem_req is 1, imem_req and imem_addr SHALL remain stable until the cycle imem_ack is 1.
REQ-019 redirect SHALL be defined as inst_valid & wpcir & (pcsource != 00); target = bpc/ra/jpc per pcsource; no delay slot.
REQ-020 IDLE: imem_req=0; next state REQ unconditionally.
REQ-021 REQ, redirect & ack: rdata discarded, inst_valid<=0, addr_q<=target, stay REQ.
REQ-022 REQ, redirect & !ack: inst_valid<=0, tgt_q<=target, addr_q unchanged, go DRAIN.
REQ-023 REQ, !redirect & ack & wpcir: pc4<=addr_q+4, inst<=imem_rdata, inst_valid<=1, addr_q<=addr_q+4, stay REQ.
REQ-024 REQ, ack & !wpcir: hold_q<=imem_rdata, IF/ID unchanged, go HOLD.
REQ-025 REQ, !ack & wpcir & !redirect: inst_valid<=0 (bubble), inst<=0; !ack & !wpcir: IF/ID unchanged.
REQ-026 HOLD (imem_req=0): !wpcir: stay, all registers unchanged; wpcir & redirect: hold_q discarded, inst_valid<=0, addr_q<=target, go REQ; wpcir & !redirect: pc4<=addr_q+4, inst<=hold_q, inst_valid<=1, addr_q<=addr_q+4, go REQ.
REQ-027 DRAIN: on ack, rdata discarded, addr_q<=tgt_q, go REQ; without ack, stay; IF/ID remains bubble (inst_valid=0) while wpcir=1.
REQ-028 Address arithmetic SHALL be modulo 2^32 (0xFFFF_FFFC + 4 = 0x0000_0000); bits [1:0] of targets SHALL be forced to 00.
REQ-029 Best-case throughput SHALL be one instruction per cycle with ack held at 1; fetch-to-IF/ID latency one cycle after ack.

Reset
REQ-030 While clrn=0: state=IDLE, addr_q=RESET_PC, tgt_q=0, hold_q=0, pc4=0, inst=0, inst_valid=0, imem_req=0, independent of clk.
REQ-031 Reset asserted mid-request or in HOLD/DRAIN SHALL abandon the transaction; the first request after release SHALL be to RESET_PC, one cycle after the first clock edge.

Verification
REQ-032 Reset release, ack always 1, rdata=addr -> imem_req rises cycle 1 at 0x0; IF/ID shows (pc4=4, inst=0), (8,4), (0xC,8) on consecutive cycles.
REQ-033 Ack delayed 3 cycles on addr 0x10, wpcir=1 -> req/addr stable 0x10 for all 4 cycles, inst_valid=0 for 3 cycles, then pc4=0x14.
REQ-034 wpcir=0 for 2 cycles while ack arrives for 0x20 -> HOLD, imem_req=0, IF/ID frozen; on wpcir=1 inst=rdata(0x20), pc4=0x24, next request 0x24.
REQ-035 Valid branch in ID, pcsource=01, bpc=0x100, ack same cycle -> sequential word discarded, inst_valid=0 next cycle, next request 0x100.
REQ-036 pcsource=11, jpc=0x200 while request 0x40 un-acked -> DRAIN holds 0x40 until ack, data discarded, next request 0x200; pcsource=10 with ra=0x303 -> request 0x300.
REQ-037 clrn pulsed low in DRAIN -> all outputs 0 immediately; after release first request 0x0; addr 0xFFFF_FFFC acked -> next request 0x0.
